scanner_ring_ctrl: RTL
======================

# scanner_ring_ctrl

Parametrised controller for a ring of N_SCAN buffered scanners. Each scanner fills a local buffer at a divided-clock rate and hands collection to its successor. At a wake threshold the successor is raised to standby. At a handoff threshold it starts scanning. An unsent full buffer that is needed again is flushed and counted as lost. The block sits between the debounced user keys and the HEX/LED display logic; it generalises the two-scanner system to N scanners, with configurable depth, thresholds and tick rate, plus a loss indication.

## Interface
- N_SCAN, 2: scanner count; legal values 2..8.
- DEPTH, 10: buffer capacity in units; must be ≥ 2.
- WAKE_AT, 5: fill level that sends go_standby to the successor; 1 ≤ WAKE_AT < HANDOFF_AT.
- HANDOFF_AT, 8: fill level that sends start_scan to the successor; HANDOFF_AT < DEPTH.
- TICK_DIV, 24: collect/transfer rate is one unit per 2^TICK_DIV clocks; must be ≥ 1.
- Derived: CW = $clog2(DEPTH+1).
- Ports:
  - clk  in  1  system clock.
  - reset  in  1  asynchronous, active-high; clears all state.
  - start_system  in  1  single-cycle pulse; wakes scanner 0.
  - start_scan  in  1  single-cycle pulse; starts scanner 0.
  - start_transfer  in  1  single-cycle pulse; transfer request.
  - state_o  out  3*N_SCAN  per-scanner state, slice i = scanner i.
  - count_o  out  CW*N_SCAN  per-scanner fill level.
  - standby_req_o  out  N_SCAN  bit i = go_standby pulse issued by scanner i.
  - scan_req_o  out  N_SCAN  bit i = start_scan pulse issued by scanner i.
  - lost_o  out  N_SCAN  sticky; scanner i has flushed unsent data.
  - tick_led  out  1  divider bit TICK_DIV.

## Operation
- State encoding: LOWPOWER=0, STANDBY=1, COLLECTING=2, IDLE=3, TRANSFERRING=4, FLUSHING=5.
- Ring order: the predecessor of scanner i is (i−1) mod N_SCAN; its successor is (i+1) mod N_SCAN.
- Divider: free-running counter, TICK_DIV+1 bits. tick is a one-cycle pulse when the low TICK_DIV bits are all ones.
- LOWPOWER:
  - → STANDBY on predecessor go_standby, or on start_system (scanner 0 only).
  - → COLLECTING directly on predecessor start_scan.
- STANDBY: → COLLECTING on predecessor start_scan, or on user start_scan (scanner 0 only).
- COLLECTING:
  - count += 1 per tick.
  - On the edge where count becomes WAKE_AT, the registered standby_req bit is set for exactly one cycle.
  - On the edge where count becomes HANDOFF_AT, the scan_req bit is set for exactly one cycle.
  - On the edge where count becomes DEPTH, the scanner moves to IDLE.
  - No requests are accepted in this state.
- IDLE:
  - start_transfer → TRANSFERRING, applied only to the lowest-index IDLE scanner.
  - Predecessor start_scan → FLUSHING, and lost_o[i] is set.
  - go_standby is ignored.
- TRANSFERRING:
  - count −= 1 per tick; at count 0 → LOWPOWER.
  - Predecessor start_scan → FLUSHING; lost_o[i] is set.
- FLUSHING: count −= 1 every clock, not tick-gated. When count reaches 0 → COLLECTING.
- count never exceeds DEPTH and never underflows below 0.
- User inputs that do not match the rules above are ignored.

## Timing
- Reset values: all states LOWPOWER; all counts 0; divider 0; req outputs 0; lost_o 0; tick_led 0.
- Reset mid-operation: everything returns to reset values immediately, asynchronously.
- Request-driven and user-driven transitions occur at the first clk edge on which the pulse is sampled, i.e. one cycle after the request appears.
- Count changes only on tick edges, except in FLUSHING.
- Simultaneous events:
  - start_scan in the same cycle as go_standby → start_scan wins.
  - A tick coinciding with a state-changing request: the request transition takes effect, and count is not incremented on that edge.
  - A tick while start_transfer moves a scanner from IDLE → TRANSFERRING: count stays DEPTH on that edge.

## Structure
- Package scanner_pkg holds:
  - the state enum (3 bits);
  - the request encoding: INACTIVE, GO_TO_STANDBY, START_SCAN, START_FLUSH;
  - a helper for CW.
- Sub-module scanner_cell holds one scanner FSM, its counter, its request outputs and its lost flag. The top level generates N_SCAN instances and wires the ring.
- The top level contains the divider and the lowest-index IDLE priority encoder for start_transfer.

## Test plan
All scenarios use N_SCAN=3, DEPTH=10, WAKE_AT=5, HANDOFF_AT=8, TICK_DIV=2.
- Reset, then start_system → state0=1. Then start_scan → state0=2. count0 reaches 5 after 5 ticks (20 clocks); standby_req_o[0] pulses for 1 cycle; state1=1 on the next edge.
- count0=8 → scan_req_o[0] pulses and state1=2 one cycle later. count0=10 → state0=3.
- Full rotation 0→1→2→0: scanner 0 is still IDLE when scanner 2 hits 8 → state0=5, lost_o[0]=1, count0 decrements 10→0 in 10 clocks, then state0=2.
- Scanners 0 and 1 both IDLE, then start_transfer → only scanner 0 → 4. count0 drains by 1 per tick and scanner 0 → LOWPOWER at 0. Scanner 1 stays 3.
- Assert reset mid-TRANSFERRING → all outputs return to reset values without a clk edge.
- A start_scan pulse while scanner 0 is in LOWPOWER or COLLECTING → no state change.

Source files
------------

// File: rtl/scanner_pkg.sv
// scanner_pkg: shared types for the scanner ring controller.
// Holds the per-scanner state encoding, the ring request
// encoding and the counter-width helper.
package scanner_pkg;

   typedef enum logic [2:0] {
      ST_LOWPOWER     = 3'd0,
      ST_STANDBY      = 3'd1,
      ST_COLLECTING   = 3'd2,
      ST_IDLE         = 3'd3,
      ST_TRANSFERRING = 3'd4,
      ST_FLUSHING     = 3'd5
   } scan_state_t;

   typedef enum logic [1:0] {
      REQ_INACTIVE,
      REQ_GO_TO_STANDBY,
      REQ_START_SCAN,
      REQ_START_FLUSH
   } scan_req_t;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/scanner_cell.sv
// scanner_cell: one scanner of the ring (FSM, fill counter,
// registered wake/handoff request pulses, sticky lost flag).
// Ports: clk, reset (async, active-high); i_tick divided-rate
// strobe; i_pred_standby/i_pred_scan requests from predecessor;
// i_wake/i_start user wake/start (scanner 0 only); i_xfer
// transfer grant; o_state, o_count, o_standby_req, o_scan_req,
// o_lost.
module scanner_cell
   import scanner_pkg::*;
#(
   parameter int DEPTH      = 10,
   parameter int WAKE_AT    = 5,
   parameter int HANDOFF_AT = 8,
   parameter int CW         = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_tick,
   input  logic          i_pred_standby,
   input  logic          i_pred_scan,
   input  logic          i_wake,
   input  logic          i_start,
   input  logic          i_xfer,
   output logic [2:0]    o_state,
   output logic [CW-1:0] o_count,
   output logic          o_standby_req,
   output logic          o_scan_req,
   output logic          o_lost
);

   localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] L_WAKE  = CW'(WAKE_AT);
   localparam logic [CW-1:0] L_HAND  = CW'(HANDOFF_AT);
   localparam logic [CW-1:0] L_ONE   = CW'(1);

   scan_state_t   r_state, w_state_n;
   logic [CW-1:0] r_count, w_count_n;
   logic          r_sreq, w_sreq_n;
   logic          r_screq, w_screq_n;
   logic          r_lost, w_lost_n;
   logic [CW-1:0] w_inc, w_dec;
   scan_req_t     w_req;

   assign w_inc = r_count + L_ONE;
   assign w_dec = r_count - L_ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_LOWPOWER;
         r_count <= '0;
         r_sreq  <= 1'b0;
         r_screq <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_count <= w_count_n;
         r_sreq  <= w_sreq_n;
         r_screq <= w_screq_n;
         r_lost  <= w_lost_n;
      end
   end

   always_comb begin
      // A start_scan from the predecessor flushes a full buffer
      // that has not been (completely) sent yet.
      w_req = REQ_INACTIVE;
      if (i_pred_scan) begin
         if (r_state == ST_IDLE ||
             r_state == ST_TRANSFERRING)
            w_req = REQ_START_FLUSH;
         else
            w_req = REQ_START_SCAN;
      end else if (i_pred_standby) begin
         w_req = REQ_GO_TO_STANDBY;
      end

      w_state_n = r_state;
      w_count_n = r_count;
      w_sreq_n  = 1'b0;
      w_screq_n = 1'b0;
      w_lost_n  = r_lost;

      unique case (r_state)
         ST_LOWPOWER: begin
            if (w_req == REQ_START_SCAN)
               w_state_n = ST_COLLECTING;
            else if (w_req == REQ_GO_TO_STANDBY || i_wake)
               w_state_n = ST_STANDBY;
         end
         ST_STANDBY: begin
            if (w_req == REQ_START_SCAN || i_start)
               w_state_n = ST_COLLECTING;
         end
         ST_COLLECTING: begin
            if (i_tick) begin
               w_count_n = w_inc;
               w_sreq_n  = (w_inc == L_WAKE);
               w_screq_n = (w_inc == L_HAND);
               if (w_inc == L_DEPTH)
                  w_state_n = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (w_req == REQ_START_FLUSH) begin
               w_state_n = ST_FLUSHING;
               w_lost_n  = 1'b1;
            end else if (i_xfer) begin
               w_state_n = ST_TRANSFERRING;
            end
         end
         ST_TRANSFERRING: begin
            if (w_req == REQ_START_FLUSH) begin
               w_state_n = ST_FLUSHING;
               w_lost_n  = 1'b1;
            end else if (r_count == '0) begin
               w_state_n = ST_LOWPOWER;
            end else if (i_tick) begin
               w_count_n = w_dec;
               if (w_dec == '0)
                  w_state_n = ST_LOWPOWER;
            end
         end
         ST_FLUSHING: begin
            // Drains at full clock rate, no tick gating.
            if (r_count <= L_ONE) begin
               w_count_n = '0;
               w_state_n = ST_COLLECTING;
            end else begin
               w_count_n = w_dec;
            end
         end
         default: begin
            w_state_n = ST_LOWPOWER;
         end
      endcase
   end

   always_comb begin
      o_state       = r_state;
      o_count       = r_count;
      o_standby_req = r_sreq;
      o_scan_req    = r_screq;
      o_lost        = r_lost;
   end

endmodule

// File: rtl/scanner_ring_ctrl.sv
// scanner_ring_ctrl: ring of N_SCAN buffered scanners with a
// shared tick divider and lowest-index transfer arbitration.
// Ports: clk, reset (async, active-high); start_system,
// start_scan, start_transfer user pulses; state_o/count_o
// per-scanner slices; standby_req_o, scan_req_o, lost_o
// per-scanner bits; tick_led divider MSB.
module scanner_ring_ctrl
   import scanner_pkg::*;
#(
   parameter  int N_SCAN     = 2,
   parameter  int DEPTH      = 10,
   parameter  int WAKE_AT    = 5,
   parameter  int HANDOFF_AT = 8,
   parameter  int TICK_DIV   = 24,
   localparam int CW         = count_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_system,
   input  logic                 start_scan,
   input  logic                 start_transfer,
   output logic [3*N_SCAN-1:0]  state_o,
   output logic [CW*N_SCAN-1:0] count_o,
   output logic [N_SCAN-1:0]    standby_req_o,
   output logic [N_SCAN-1:0]    scan_req_o,
   output logic [N_SCAN-1:0]    lost_o,
   output logic                 tick_led
);

   logic [TICK_DIV:0] r_div;
   logic              w_tick;
   logic [N_SCAN-1:0] w_idle;
   logic [N_SCAN-1:0] w_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_div <= '0;
      else
         r_div <= r_div + 1'b1;
   end

   assign w_tick   = &r_div[TICK_DIV-1:0];
   assign tick_led = r_div[TICK_DIV];

   // Two's-complement trick isolates the lowest IDLE scanner.
   assign w_grant = start_transfer
                  ? (w_idle & (~w_idle + N_SCAN'(1)))
                  : '0;

   for (genvar g = 0; g < N_SCAN; g++) begin : g_cell
      localparam int P = (g + N_SCAN - 1) % N_SCAN;

      assign w_idle[g] = (state_o[3*g +: 3] == ST_IDLE);

      scanner_cell #(
         .DEPTH      (DEPTH),
         .WAKE_AT    (WAKE_AT),
         .HANDOFF_AT (HANDOFF_AT),
         .CW         (CW)
      ) u_cell (
         .clk            (clk),
         .reset          (reset),
         .i_tick         (w_tick),
         .i_pred_standby (standby_req_o[P]),
         .i_pred_scan    (scan_req_o[P]),
         .i_wake         ((g == 0) ? start_system : 1'b0),
         .i_start        ((g == 0) ? start_scan : 1'b0),
         .i_xfer         (w_grant[g]),
         .o_state        (state_o[3*g +: 3]),
         .o_count        (count_o[CW*g +: CW]),
         .o_standby_req  (standby_req_o[g]),
         .o_scan_req     (scan_req_o[g]),
         .o_lost         (lost_o[g])
      );
   end

endmodule
